icw_ocw_sequencer_8259: RTL and testbench
=========================================

Name: icw_ocw_sequencer_8259

Overview:
- Control-word sequencer directly downstream of the 8259A data-bus control stage.
- Consumes that stage's one-clock write strobes and its internal_data_bus, and steps through the ICW1 -> ICW2 -> [ICW3] -> [ICW4] initialization sequence.
- Routes A0=1 writes to either an ICW or OCW1 according to sequence state, and decodes OCW2/OCW3.
- Holds every programmed mode field and IMR for the priority resolver, ISR/IRR and cascade logic.

Parameters:
- INIT_MASK, 8'h00, IMR value loaded on reset and on every ICW1.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- internal_data_bus  in  8  latched write data from bus control.
- write_initial_command_word_1  in  1  one-clock pulse, ICW1 write.
- write_initial_command_word_2_4  in  1  one-clock pulse, A0=1 write.
- write_operation_control_word_1  in  1  one-clock pulse, A0=1 write (coincides with the ICW2-4 strobe).
- write_operation_control_word_2  in  1  one-clock pulse, OCW2 write.
- write_operation_control_word_3  in  1  one-clock pulse, OCW3 write.
- init_done  out  1  high in READY state.
- level_or_edge_triggered_config  out  1  ICW1.D3 (LTIM).
- single_or_cascade_config  out  1  ICW1.D1 (SNGL).
- vector_base  out  5  ICW2.D7:D3.
- cascade_device_config  out  8  ICW3 value.
- auto_eoi_config  out  1  ICW4.D1.
- buffered_mode_config  out  1  ICW4.D3.
- buffered_master_config  out  1  ICW4.D2.
- special_fully_nested_config  out  1  ICW4.D4.
- u8086_or_mcs80_config  out  1  ICW4.D0 (1 = 8086).
- interrupt_mask  out  8  IMR (OCW1).
- special_mask_mode  out  1  SMM.
- read_register_isr_or_irr  out  1  1 = ISR selected for read.
- poll_command  out  1  one-clock pulse on OCW3 with P=1.
- ocw2_strobe  out  1  one-clock pulse per accepted OCW2.
- ocw2_command  out  3  OCW2.D7:D5 (R, SL, EOI), valid with strobe.
- ocw2_level  out  3  OCW2.D2:D0, valid with strobe.
- clear_edge_sense  out  1  one-clock pulse on ICW1.

Behaviour:
- Reset: state UNINIT.
  - All config outputs 0; interrupt_mask = INIT_MASK.
  - special_mask_mode 0, read_register_isr_or_irr 0.
  - All pulse outputs 0.
- States: UNINIT, ICW2, ICW3, ICW4, READY. One transition per strobe.
- ICW1, accepted in any state (including mid-sequence), restarts the sequence -> next state ICW2:
  - Latch LTIM, SNGL, and IC4 (internal).
  - Clear IMR to INIT_MASK, SMM 0, read select IRR.
  - Clear all ICW4 fields to 0; pulse clear_edge_sense.
- ICW2 state, A0=1 strobe: latch vector_base.
  - Next state ICW3 if SNGL=0, else ICW4 if IC4=1, else READY.
- ICW3 state, A0=1 strobe: latch cascade_device_config. Next state ICW4 if IC4=1, else READY.
- ICW4 state, A0=1 strobe: latch D4:D0 fields. Next state READY.
- READY state, A0=1 strobe: load interrupt_mask from data (OCW1). State unchanged.
- In UNINIT, A0=1 writes are ignored.
- OCW2/OCW3 strobes outside READY are ignored; no pulses.
- OCW2 in READY: ocw2_strobe, ocw2_command and ocw2_level are registered and valid exactly one cycle after the strobe edge. Command/level hold their last value otherwise.
- OCW3 in READY:
  - D6 (ESMM)=1: SMM <= D5; otherwise SMM unchanged.
  - D1 (RR)=1: read select <= D0; otherwise unchanged.
  - D2=1: poll_command pulse one cycle later.
- Latency: all registered outputs change on the edge that samples the strobe.
- Simultaneous strobes:
  - ICW1 has priority and all others are dropped.
  - OCW2+OCW3 together are both processed.
- Asynchronous reset mid-sequence returns to UNINIT immediately.

Optional Feature:
- Macro MCS80_VECTOR_MODE_EN.
- Defined:
  - Adds output ports call_address_interval (1 bit, ICW1.D2 ADI) and mcs80_vector_high (3 bits, ICW1.D7:D5), latched on ICW1.
  - ICW2 in 8080 mode additionally latches D2:D0 to output mcs80_vector_low (3 bits).
  - u8086_or_mcs80_config follows ICW4.D0, as in the base block.
- Not defined:
  - The extra ports are absent and ICW1.D7:D5/D2 are ignored.
  - u8086_or_mcs80_config is forced to 1 after ICW4; it is 0 only in reset/ICW1-cleared state.

Test Plan:
- ICW1=8'h13 (SNGL=1, IC4=1), A0=1 8'h20, A0=1 8'h03 -> vector_base 5'h04, auto_eoi 1, u8086 1, init_done 1 after the third strobe, ICW3 skipped.
- ICW1=8'h10, A0=1 8'h40, A0=1 8'h04 -> cascade_device_config 8'h04 latched, no ICW4 state, init_done 1; then A0=1 8'hA5 -> interrupt_mask 8'hA5.
- READY, OCW2=8'h65 -> ocw2_strobe one cycle, command 3'b011, level 3'b101; OCW3=8'h6B -> SMM 1, ISR selected; OCW3=8'h0C -> poll_command pulse, SMM/read select unchanged.
- Mid-sequence (ICW3 state) ICW1=8'h1B -> state ICW2, mask back to INIT_MASK, clear_edge_sense pulse, LTIM 1.
- ICW1 and OCW2 strobes in the same cycle in READY -> no ocw2_strobe, state ICW2.
- Assert reset_n low during ICW4 state, no clock edge -> init_done 0 and mask INIT_MASK immediately; OCW2 before reinitialization ignored.

Source files
------------

// File: rtl/icw_ocw_sequencer_8259.sv
// 8259A control-word sequencer: ICW1..ICW4 initialization, OCW1 mask, OCW2/OCW3 decode.
// Optional MCS80_VECTOR_MODE_EN adds the 8080 call-address fields (ADI, vector high/low).
module icw_ocw_sequencer_8259 #(
    parameter logic [7:0] INIT_MASK = 8'h00
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [7:0] internal_data_bus,
    input  logic       write_initial_command_word_1,
    input  logic       write_initial_command_word_2_4,
    input  logic       write_operation_control_word_1,
    input  logic       write_operation_control_word_2,
    input  logic       write_operation_control_word_3,
    output logic       init_done,
    output logic       level_or_edge_triggered_config,
    output logic       single_or_cascade_config,
    output logic [4:0] vector_base,
    output logic [7:0] cascade_device_config,
    output logic       auto_eoi_config,
    output logic       buffered_mode_config,
    output logic       buffered_master_config,
    output logic       special_fully_nested_config,
    output logic       u8086_or_mcs80_config,
    output logic [7:0] interrupt_mask,
    output logic       special_mask_mode,
    output logic       read_register_isr_or_irr,
    output logic       poll_command,
    output logic       ocw2_strobe,
    output logic [2:0] ocw2_command,
    output logic [2:0] ocw2_level,
`ifdef MCS80_VECTOR_MODE_EN
    output logic       call_address_interval,
    output logic [2:0] mcs80_vector_high,
    output logic [2:0] mcs80_vector_low,
`endif
    output logic       clear_edge_sense
);

    // state   | meaning
    // UNINIT  | no ICW1 seen since reset; A0=1 writes ignored
    // ICW2    | next A0=1 write is ICW2 (vector base)
    // ICW3    | next A0=1 write is ICW3 (cascade config)
    // ICW4    | next A0=1 write is ICW4 (mode fields)
    // READY   | A0=1 writes are OCW1; OCW2/OCW3 accepted
    typedef enum logic [2:0] {
        S_UNINIT = 3'd0,
        S_ICW2   = 3'd1,
        S_ICW3   = 3'd2,
        S_ICW4   = 3'd3,
        S_READY  = 3'd4
    } state_t;

    state_t     r_state;
    state_t     w_next_state;

    logic       w_icw1;
    logic       w_a0_write;
    logic       w_ocw2_accept;
    logic       w_ocw3_accept;
    logic [7:0] w_d;

    logic       r_ltim;
    logic       r_sngl;
    logic       r_ic4;
    logic [4:0] r_vector_base;
    logic [7:0] r_cascade;
    logic       r_aeoi;
    logic       r_buf;
    logic       r_buf_master;
    logic       r_sfnm;
    logic       r_upm;
    logic [7:0] r_imr;
    logic       r_smm;
    logic       r_rr_isr;
    logic       r_poll;
    logic       r_ocw2_strobe;
    logic [2:0] r_ocw2_command;
    logic [2:0] r_ocw2_level;
    logic       r_clear_edge;
`ifdef MCS80_VECTOR_MODE_EN
    logic       r_adi;
    logic [2:0] r_vec_high;
    logic [2:0] r_vec_low;
`endif

    assign w_d = internal_data_bus;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= S_UNINIT;
        else          r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        if (w_icw1) begin
            w_next_state = S_ICW2;
        end else if (w_a0_write) begin
            case (r_state)
                S_ICW2:  w_next_state = !r_sngl ? S_ICW3 : (r_ic4 ? S_ICW4 : S_READY);
                S_ICW3:  w_next_state = r_ic4 ? S_ICW4 : S_READY;
                S_ICW4:  w_next_state = S_READY;
                default: w_next_state = r_state;
            endcase
        end
    end

    // ICW1 wins over every other strobe arriving in the same cycle.
    always_comb begin
        w_icw1        = write_initial_command_word_1;
        w_a0_write    = (write_initial_command_word_2_4 | write_operation_control_word_1) & ~w_icw1;
        init_done     = (r_state == S_READY);
        w_ocw2_accept = write_operation_control_word_2 & ~w_icw1 & init_done;
        w_ocw3_accept = write_operation_control_word_3 & ~w_icw1 & init_done;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_ltim         <= 1'b0;
            r_sngl         <= 1'b0;
            r_ic4          <= 1'b0;
            r_vector_base  <= 5'd0;
            r_cascade      <= 8'd0;
            r_aeoi         <= 1'b0;
            r_buf          <= 1'b0;
            r_buf_master   <= 1'b0;
            r_sfnm         <= 1'b0;
            r_upm          <= 1'b0;
            r_imr          <= INIT_MASK;
            r_smm          <= 1'b0;
            r_rr_isr       <= 1'b0;
            r_poll         <= 1'b0;
            r_ocw2_strobe  <= 1'b0;
            r_ocw2_command <= 3'd0;
            r_ocw2_level   <= 3'd0;
            r_clear_edge   <= 1'b0;
`ifdef MCS80_VECTOR_MODE_EN
            r_adi          <= 1'b0;
            r_vec_high     <= 3'd0;
            r_vec_low      <= 3'd0;
`endif
        end else begin
            r_clear_edge  <= w_icw1;
            r_ocw2_strobe <= w_ocw2_accept;
            r_poll        <= w_ocw3_accept & w_d[2];
            if (w_icw1) begin
                r_ltim       <= w_d[3];
                r_sngl       <= w_d[1];
                r_ic4        <= w_d[0];
                r_imr        <= INIT_MASK;
                r_smm        <= 1'b0;
                r_rr_isr     <= 1'b0;
                r_aeoi       <= 1'b0;
                r_buf        <= 1'b0;
                r_buf_master <= 1'b0;
                r_sfnm       <= 1'b0;
                r_upm        <= 1'b0;
`ifdef MCS80_VECTOR_MODE_EN
                r_adi        <= w_d[2];
                r_vec_high   <= w_d[7:5];
`endif
            end else if (w_a0_write) begin
                case (r_state)
                    S_ICW2: begin
                        r_vector_base <= w_d[7:3];
`ifdef MCS80_VECTOR_MODE_EN
                        r_vec_low     <= w_d[2:0];
`endif
                    end
                    S_ICW3: r_cascade <= w_d;
                    S_ICW4: begin
                        r_sfnm       <= w_d[4];
                        r_buf        <= w_d[3];
                        r_buf_master <= w_d[2];
                        r_aeoi       <= w_d[1];
`ifdef MCS80_VECTOR_MODE_EN
                        r_upm        <= w_d[0];
`else
                        // Without 8080 vectoring only 8086 mode is meaningful.
                        r_upm        <= 1'b1;
`endif
                    end
                    S_READY: r_imr <= w_d;
                    default: ;
                endcase
            end
            if (w_ocw2_accept) begin
                r_ocw2_command <= w_d[7:5];
                r_ocw2_level   <= w_d[2:0];
            end
            if (w_ocw3_accept) begin
                if (w_d[6]) r_smm    <= w_d[5];
                if (w_d[1]) r_rr_isr <= w_d[0];
            end
        end
    end

    assign level_or_edge_triggered_config = r_ltim;
    assign single_or_cascade_config       = r_sngl;
    assign vector_base                    = r_vector_base;
    assign cascade_device_config          = r_cascade;
    assign auto_eoi_config                = r_aeoi;
    assign buffered_mode_config           = r_buf;
    assign buffered_master_config         = r_buf_master;
    assign special_fully_nested_config    = r_sfnm;
    assign u8086_or_mcs80_config          = r_upm;
    assign interrupt_mask                 = r_imr;
    assign special_mask_mode              = r_smm;
    assign read_register_isr_or_irr       = r_rr_isr;
    assign poll_command                   = r_poll;
    assign ocw2_strobe                    = r_ocw2_strobe;
    assign ocw2_command                   = r_ocw2_command;
    assign ocw2_level                     = r_ocw2_level;
    assign clear_edge_sense               = r_clear_edge;
`ifdef MCS80_VECTOR_MODE_EN
    assign call_address_interval          = r_adi;
    assign mcs80_vector_high              = r_vec_high;
    assign mcs80_vector_low               = r_vec_low;
`endif

endmodule

// File: tb/tb_icw_ocw_sequencer_8259.sv
// Bench for icw_ocw_sequencer_8259 (default build): directed plan plus random strobes
// checked against a queue-based model of the pending initialization words.
module tb_icw_ocw_sequencer_8259;
    localparam logic [7:0] MASK0 = 8'h5A;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] data = 8'h00;
    logic       s_icw1 = 1'b0, s_icw24 = 1'b0, s_ocw1 = 1'b0, s_ocw2 = 1'b0, s_ocw3 = 1'b0;

    logic       init_done, ltim, sngl, aeoi, bufm, bufms, sfnm, u86, smm, rr, poll, o2s, clr;
    logic [4:0] vb;
    logic [7:0] cas, imr;
    logic [2:0] o2c, o2l;

    icw_ocw_sequencer_8259 #(.INIT_MASK(MASK0)) dut (
        .clock(clock), .reset_n(reset_n), .internal_data_bus(data),
        .write_initial_command_word_1(s_icw1),
        .write_initial_command_word_2_4(s_icw24),
        .write_operation_control_word_1(s_ocw1),
        .write_operation_control_word_2(s_ocw2),
        .write_operation_control_word_3(s_ocw3),
        .init_done(init_done), .level_or_edge_triggered_config(ltim),
        .single_or_cascade_config(sngl), .vector_base(vb),
        .cascade_device_config(cas), .auto_eoi_config(aeoi),
        .buffered_mode_config(bufm), .buffered_master_config(bufms),
        .special_fully_nested_config(sfnm), .u8086_or_mcs80_config(u86),
        .interrupt_mask(imr), .special_mask_mode(smm),
        .read_register_isr_or_irr(rr), .poll_command(poll),
        .ocw2_strobe(o2s), .ocw2_command(o2c), .ocw2_level(o2l),
        .clear_edge_sense(clr)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Model: list of ICW numbers still owed after the last ICW1.
    int         pend[$];
    bit         m_inited;
    logic       m_ltim, m_sngl, m_aeoi, m_buf, m_bufms, m_sfnm, m_u86, m_smm, m_rr;
    logic       m_poll, m_o2s, m_clr;
    logic [4:0] m_vb;
    logic [7:0] m_cas, m_imr;
    logic [2:0] m_o2c, m_o2l;

    task automatic model_reset();
        pend.delete();
        m_inited = 0;
        {m_ltim, m_sngl, m_aeoi, m_buf, m_bufms, m_sfnm, m_u86, m_smm, m_rr} = '0;
        {m_poll, m_o2s, m_clr} = '0;
        m_vb = '0; m_cas = '0; m_imr = MASK0; m_o2c = '0; m_o2l = '0;
    endtask

    task automatic model_update(input bit i1, input bit a0, input bit o2, input bit o3,
                                input logic [7:0] d);
        bit ready;
        int w;
        ready = m_inited && (pend.size() == 0);
        m_poll = 0; m_o2s = 0; m_clr = 0;
        if (i1) begin
            m_inited = 1;
            m_ltim = d[3]; m_sngl = d[1];
            pend.delete();
            pend.push_back(2);
            if (!d[1]) pend.push_back(3);
            if (d[0])  pend.push_back(4);
            m_imr = MASK0; m_smm = 0; m_rr = 0;
            {m_aeoi, m_buf, m_bufms, m_sfnm, m_u86} = '0;
            m_clr = 1;
        end else begin
            if (a0 && m_inited) begin
                if (pend.size() == 0) m_imr = d;
                else begin
                    w = pend.pop_front();
                    if (w == 2) m_vb = d[7:3];
                    else if (w == 3) m_cas = d;
                    else begin
                        m_sfnm = d[4]; m_buf = d[3]; m_bufms = d[2]; m_aeoi = d[1]; m_u86 = 1;
                    end
                end
            end
            if (o2 && ready) begin
                m_o2s = 1; m_o2c = d[7:5]; m_o2l = d[2:0];
            end
            if (o3 && ready) begin
                if (d[6]) m_smm = d[5];
                if (d[1]) m_rr = d[0];
                if (d[2]) m_poll = 1;
            end
        end
    endtask

    task automatic check_all();
        chk("init_done", init_done, m_inited && pend.size() == 0);
        chk("ltim", ltim, m_ltim);
        chk("sngl", sngl, m_sngl);
        chk("vector_base", vb, m_vb);
        chk("cascade", cas, m_cas);
        chk("aeoi", aeoi, m_aeoi);
        chk("buf", bufm, m_buf);
        chk("buf_master", bufms, m_bufms);
        chk("sfnm", sfnm, m_sfnm);
        chk("u8086", u86, m_u86);
        chk("imr", imr, m_imr);
        chk("smm", smm, m_smm);
        chk("rr", rr, m_rr);
        chk("poll", poll, m_poll);
        chk("ocw2_strobe", o2s, m_o2s);
        chk("ocw2_cmd", o2c, m_o2c);
        chk("ocw2_lvl", o2l, m_o2l);
        chk("clear_edge", clr, m_clr);
    endtask

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic step(input bit i1, input bit a0, input bit o2, input bit o3,
                        input logic [7:0] d);
        data = d; s_icw1 = i1; s_icw24 = a0; s_ocw1 = a0; s_ocw2 = o2; s_ocw3 = o3;
        @(posedge clock);
        model_update(i1, a0, o2, o3, d);
        @(negedge clock);
        s_icw1 = 0; s_icw24 = 0; s_ocw1 = 0; s_ocw2 = 0; s_ocw3 = 0;
        check_all();
    endtask

    initial begin
        int r;
        model_reset();
        @(negedge clock);
        check_all();
        reset_n = 1'b1;

        // A0=1 ignored before any ICW1
        step(0, 1, 0, 0, 8'h77);
        step(0, 0, 1, 1, 8'hFF);

        // single, ICW4 present: ICW3 skipped
        step(1, 0, 0, 0, 8'h13);
        step(0, 1, 0, 0, 8'h20);
        chk("skip_icw3_not_ready", init_done, 1'b0);
        step(0, 1, 0, 0, 8'h03);
        chk("plan1_vb", vb, 5'h04);
        chk("plan1_aeoi", aeoi, 1'b1);
        chk("plan1_u86", u86, 1'b1);
        chk("plan1_done", init_done, 1'b1);

        // cascade, no ICW4, then OCW1
        step(1, 0, 0, 0, 8'h10);
        step(0, 1, 0, 0, 8'h40);
        step(0, 1, 0, 0, 8'h04);
        chk("plan2_cas", cas, 8'h04);
        chk("plan2_done", init_done, 1'b1);
        step(0, 1, 0, 0, 8'hA5);
        chk("plan2_imr", imr, 8'hA5);

        // OCW2 / OCW3 in READY
        step(0, 0, 1, 0, 8'h65);
        chk("plan3_o2s", o2s, 1'b1);
        chk("plan3_o2c", o2c, 3'b011);
        chk("plan3_o2l", o2l, 3'b101);
        step(0, 0, 0, 0, 8'h00);
        chk("plan3_o2s_drop", o2s, 1'b0);
        step(0, 0, 0, 1, 8'h6B);
        chk("plan3_smm", smm, 1'b1);
        chk("plan3_rr", rr, 1'b1);
        step(0, 0, 0, 1, 8'h0C);
        chk("plan3_poll", poll, 1'b1);
        chk("plan3_smm_hold", smm, 1'b1);
        chk("plan3_rr_hold", rr, 1'b1);

        // restart from ICW3 state
        step(1, 0, 0, 0, 8'h10);
        step(0, 1, 0, 0, 8'h40);
        step(1, 0, 0, 0, 8'h1B);
        chk("plan4_clr", clr, 1'b1);
        chk("plan4_ltim", ltim, 1'b1);
        chk("plan4_imr", imr, MASK0);
        chk("plan4_not_ready", init_done, 1'b0);
        step(0, 1, 0, 0, 8'h08);
        step(0, 1, 0, 0, 8'h01);
        chk("plan4_done", init_done, 1'b1);

        // ICW1 with OCW2 in READY
        step(1, 0, 1, 0, 8'h13);
        chk("plan5_o2s", o2s, 1'b0);
        chk("plan5_state", init_done, 1'b0);

        // async reset while in ICW4 state
        step(0, 1, 0, 0, 8'h08);
        step(0, 1, 0, 0, 8'hFF);
        step(1, 0, 0, 0, 8'h13);
        step(0, 1, 0, 0, 8'h08);
        #2 reset_n = 1'b0;
        #1;
        chk("plan6_done", init_done, 1'b0);
        chk("plan6_imr", imr, MASK0);
        model_reset();
        check_all();
        reset_n = 1'b1;
        @(negedge clock);
        step(0, 0, 1, 0, 8'h65);
        chk("plan6_o2s", o2s, 1'b0);

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(149) == 0) begin
                reset_n = 1'b0;
                #1;
                model_reset();
                check_all();
                reset_n = 1'b1;
            end else begin
                r = $urandom_range(11);
                step(r == 0 || r == 9, (r >= 1 && r <= 4) || r == 9,
                     r == 5 || r == 6 || r == 7 || r == 9, r == 7 || r == 8 || r == 10,
                     8'($urandom));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete, expected completion");
        $fatal(1, "timeout");
    end
endmodule
